neo_clk_ce_gen: RTL and testbench

NEO_CLK_CE_GEN -- requirements
Module: neo_clk_ce_gen

---
 rtl/neo_clk_ce_gen.sv | 171 +++++++++++++++++
 tb/tb_neo_clk_ce_gen.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neo_clk_ce_gen.sv
// ----------------------------------------------------------------------------
// neo_clk_ce_gen
//
// Reset release sequencer and clock-enable generator for a core running from
// a single 144 MHz PLL clock.
//
// The asynchronous PLL lock flag passes through a two-flop synchronizer. The
// core stays in reset until the synchronized lock has been stable for
// STABLE_CYCLES cycles. While the sequencer is in RUN, a mod-72 divider
// produces the one-cycle enable pulses listed below.
//
// Parameters:
//   STABLE_CYCLES  consecutive synchronized-lock cycles needed before
//                  core_reset is released (2..65535)
//
// Build option:
//   NEO_CLK_CE_PAUSE_EN  when defined, pause gates ce_68k and ce_z80.
//                        When undefined, pause is ignored, ce_68k equals
//                        ce_12m and ce_z80 equals ce_4m.
//
// Ports:
//   clk_sys     in   144 MHz system clock, the only clock of the block
//   rst         in   synchronous active-high reset
//   pll_locked  in   asynchronous PLL lock indication
//   pause       in   CPU pause request (synchronous to clk_sys)
//   core_reset  out  active-high reset for the downstream core
//   ce_24m      out  one-cycle pulse every 6 clk_sys
//   ce_12m      out  one-cycle pulse every 12 clk_sys
//   ce_6m       out  one-cycle pixel pulse every 24 clk_sys
//   ce_4m       out  one-cycle pulse every 36 clk_sys
//   ce_68k      out  68000 enable, 12 MHz rate, optionally pause-gated
//   ce_z80      out  Z80 enable, 4 MHz rate, optionally pause-gated
//   state_dbg   out  current sequencer state (0 WAIT_LOCK, 1 STABLE, 2 RUN)
//
// Handshake: there is no valid/ready interface. Every output is a registered
// level or a single-cycle strobe, and it is valid in the cycle after the
// clk_sys edge that produced it.
// ----------------------------------------------------------------------------
module neo_clk_ce_gen #(
    parameter int STABLE_CYCLES = 1024
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       pause,
    output logic       core_reset,
    output logic       ce_24m,
    output logic       ce_12m,
    output logic       ce_6m,
    output logic       ce_4m,
    output logic       ce_68k,
    output logic       ce_z80,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam logic [15:0] STAB_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [6:0]  CNT_LAST  = 7'd71;

    state_t      state;
    logic        lk_s1;
    logic        lk_s2;
    logic [15:0] stab_cnt;
    logic [6:0]  cnt;

    // Divider phase hits. Each one is true in the last cycle of its period,
    // so the registered enable rises in the cycle after the hit.
    logic hit_6;
    logic hit_12;
    logic hit_24;
    logic hit_36;
    logic cpu_en;

    assign hit_6  = (cnt % 7'd6)  == 7'd5;
    assign hit_12 = (cnt % 7'd12) == 7'd11;
    assign hit_24 = (cnt % 7'd24) == 7'd23;
    assign hit_36 = (cnt % 7'd36) == 7'd35;

`ifdef NEO_CLK_CE_PAUSE_EN
    // pause is sampled on the same edge as the divider hit it gates.
    assign cpu_en = ~pause;
`else
    // In this build pause is read but has no effect, so the CPU enables
    // follow the 12 MHz and 4 MHz pulses exactly.
    assign cpu_en = pause | ~pause;
`endif

    assign state_dbg = state;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            lk_s1      <= 1'b0;
            lk_s2      <= 1'b0;
            stab_cnt   <= 16'd0;
            cnt        <= 7'd0;
            core_reset <= 1'b1;
            ce_24m     <= 1'b0;
            ce_12m     <= 1'b0;
            ce_6m      <= 1'b0;
            ce_4m      <= 1'b0;
            ce_68k     <= 1'b0;
            ce_z80     <= 1'b0;
        end else begin
            lk_s1 <= pll_locked;
            lk_s2 <= lk_s1;

            // The enables stay low unless RUN with good lock sets them below.
            // This also clears them on the edge where lock is lost.
            ce_24m <= 1'b0;
            ce_12m <= 1'b0;
            ce_6m  <= 1'b0;
            ce_4m  <= 1'b0;
            ce_68k <= 1'b0;
            ce_z80 <= 1'b0;

            if (!lk_s2) begin
                // Lock lost or not yet present: restart from scratch in any state.
                state      <= WAIT_LOCK;
                stab_cnt   <= 16'd0;
                cnt        <= 7'd0;
                core_reset <= 1'b1;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        state      <= STABLE;
                        stab_cnt   <= 16'd0;
                        cnt        <= 7'd0;
                        core_reset <= 1'b1;
                    end

                    STABLE: begin
                        cnt        <= 7'd0;
                        stab_cnt   <= stab_cnt + 16'd1;
                        core_reset <= 1'b1;
                        if (stab_cnt == STAB_LAST) begin
                            // Register the reset release together with the
                            // state change so core_reset is low exactly in RUN.
                            state      <= RUN;
                            core_reset <= 1'b0;
                        end
                    end

                    RUN: begin
                        core_reset <= 1'b0;
                        cnt        <= (cnt == CNT_LAST) ? 7'd0 : cnt + 7'd1;
                        ce_24m     <= hit_6;
                        ce_12m     <= hit_12;
                        ce_6m      <= hit_24;
                        ce_4m      <= hit_36;
                        ce_68k     <= hit_12 & cpu_en;
                        ce_z80     <= hit_36 & cpu_en;
                    end

                    default: begin
                        state      <= WAIT_LOCK;
                        stab_cnt   <= 16'd0;
                        cnt        <= 7'd0;
                        core_reset <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_neo_clk_ce_gen.sv
// ----------------------------------------------------------------------------
// tb_neo_clk_ce_gen
//
// Outputs are packed as {core_reset, ce_24m, ce_12m, ce_6m, ce_4m, ce_68k,
// ce_z80}. Expected vectors come from the release timeline. k is the number
// of clk_sys edges since the edge that released core_reset. A divide-by-D
// enable is high when k > 0 and k % D == 0.
// ----------------------------------------------------------------------------
module tb_neo_clk_ce_gen;

    localparam int STAB = 1024;
    localparam int REL  = STAB + 2;   // core_reset low after edge E(REL)
    localparam int W    = 7;

    logic       clk_sys;
    logic       rst;
    logic       pll_locked;
    logic       pause;
    logic       core_reset;
    logic       ce_24m;
    logic       ce_12m;
    logic       ce_6m;
    logic       ce_4m;
    logic       ce_68k;
    logic       ce_z80;
    logic [1:0] state_dbg;

    logic [W-1:0] exp_q[$];

    int n_checks;
    int n_fail;
    int k_rel;

    // ---------------- clock / reset ----------------
    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    neo_clk_ce_gen #(.STABLE_CYCLES(STAB)) dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pause      (pause),
        .core_reset (core_reset),
        .ce_24m     (ce_24m),
        .ce_12m     (ce_12m),
        .ce_6m      (ce_6m),
        .ce_4m      (ce_4m),
        .ce_68k     (ce_68k),
        .ce_z80     (ce_z80),
        .state_dbg  (state_dbg)
    );

    function automatic logic [W-1:0] act_vec();
        return {core_reset, ce_24m, ce_12m, ce_6m, ce_4m, ce_68k, ce_z80};
    endfunction

    // Expected output vector, k edges after release, paused = pause value at that edge.
    function automatic logic [W-1:0] exp_vec(input bit in_reset, input int k, input bit paused);
        logic c24, c12, c6, c4, c68, cz;
        if (in_reset) return 7'b1000000;
        c24 = (k > 0) && (k % 6 == 0);
        c12 = (k > 0) && (k % 12 == 0);
        c6  = (k > 0) && (k % 24 == 0);
        c4  = (k > 0) && (k % 36 == 0);
`ifdef NEO_CLK_CE_PAUSE_EN
        c68 = c12 && !paused;
        cz  = c4 && !paused;
`else
        c68 = c12;
        cz  = c4;
        if (paused) begin
            c68 = c12;
        end
`endif
        return {1'b0, c24, c12, c6, c4, c68, cz};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [W-1:0] e, a;
        rst = 1'b1;
        pll_locked = 1'b0;
        pause = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(7'b1000000);
            @(negedge clk_sys);
            e = exp_q.pop_front();
            a = act_vec();
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got=%b exp=%b", i, a, e);
            end
            n_checks++;
            if (state_dbg !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_state cyc=%0d got=%0d exp=0", i, state_dbg);
            end
        end
    endtask

    task automatic test_lock_up();
        logic [W-1:0] e, a;
        int first_ce24;
        first_ce24 = -1;
        rst = 1'b0;
        pll_locked = 1'b1;            // next edge is E0
        for (int j = 0; j <= REL + 80; j++) begin
            exp_q.push_back(exp_vec(j < REL, j - REL, 1'b0));
            @(negedge clk_sys);
            e = exp_q.pop_front();
            a = act_vec();
            if (ce_24m === 1'b1 && first_ce24 < 0) first_ce24 = j;
            if (j >= REL - 3) begin
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL lock_up edge=E%0d got=%b exp=%b", j, a, e);
                end
            end else if (a !== e) begin
                n_checks++;
                n_fail++;
                $display("FAIL lock_up_hold edge=E%0d got=%b exp=%b", j, a, e);
            end
        end
        k_rel = 80;
        n_checks++;
        if (first_ce24 != REL + 6) begin
            n_fail++;
            $display("FAIL first_ce24 got=E%0d exp=E%0d", first_ce24, REL + 6);
        end
        n_checks++;
        if (state_dbg !== 2'd2) begin
            n_fail++;
            $display("FAIL lock_up_state got=%0d exp=2", state_dbg);
        end
    endtask

    task automatic test_rates();
        logic [W-1:0] e, a, prev;
        int n24, n12, n6, n4;
        n24 = 0; n12 = 0; n6 = 0; n4 = 0;
        prev = act_vec();
        for (int i = 0; i < 720; i++) begin
            exp_q.push_back(exp_vec(1'b0, k_rel + 1, 1'b0));
            @(negedge clk_sys);
            k_rel++;
            e = exp_q.pop_front();
            a = act_vec();
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL rates k=%0d got=%b exp=%b", k_rel, a, e);
            end
            n_checks++;
            if ((a[5:2] & prev[5:2]) !== 4'b0000) begin
                n_fail++;
                $display("FAIL pulse_width k=%0d got=%b prev=%b exp=single-cycle", k_rel, a, prev);
            end
            n24 += int'(a[5]);
            n12 += int'(a[4]);
            n6  += int'(a[3]);
            n4  += int'(a[2]);
            prev = a;
        end
        n_checks++;
        if (n24 != 120 || n12 != 60 || n6 != 30 || n4 != 20) begin
            n_fail++;
            $display("FAIL rate_counts got=%0d/%0d/%0d/%0d exp=120/60/30/20", n24, n12, n6, n4);
        end
    endtask

    task automatic test_lock_loss();
        logic [W-1:0] e, a;
        pll_locked = 1'b0;            // next edge F0 samples the drop
        for (int j = 0; j < 6; j++) begin
            exp_q.push_back(exp_vec(j >= 2, k_rel + j + 1, 1'b0));
            @(negedge clk_sys);
            e = exp_q.pop_front();
            a = act_vec();
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL lock_loss edge=F%0d got=%b exp=%b", j, a, e);
            end
        end
        n_checks++;
        if (state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL lock_loss_state got=%0d exp=0", state_dbg);
        end
    endtask

    task automatic test_lock_glitch();
        logic [W-1:0] e, a;
        localparam int GLITCH_E = 503;        // edge sampling the low glitch
        localparam int RELOCK_E0 = GLITCH_E + 1;
        localparam int REL2 = RELOCK_E0 + REL;
        pll_locked = 1'b1;
        for (int j = 0; j <= REL2 + 40; j++) begin
            exp_q.push_back(exp_vec(j < REL2, j - REL2, 1'b0));
            @(negedge clk_sys);
            e = exp_q.pop_front();
            a = act_vec();
            if (j == GLITCH_E - 1) pll_locked = 1'b0;   // stab_cnt is 500 now
            if (j == GLITCH_E) pll_locked = 1'b1;
            if (j >= REL2 - 2 || j == REL - 1 || j == REL) begin
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL lock_glitch edge=E%0d got=%b exp=%b", j, a, e);
                end
            end else if (a !== e) begin
                n_checks++;
                n_fail++;
                $display("FAIL lock_glitch_hold edge=E%0d got=%b exp=%b", j, a, e);
            end
        end
        k_rel = 40;
    endtask

    task automatic test_pause();
        logic [W-1:0] e, a;
        int n6, n68, nz;
        n6 = 0; n68 = 0; nz = 0;
        pause = 1'b1;
        for (int i = 0; i < 84; i++) begin
            if (i == 72) pause = 1'b0;
            exp_q.push_back(exp_vec(1'b0, k_rel + 1, pause));
            @(negedge clk_sys);
            k_rel++;
            e = exp_q.pop_front();
            a = act_vec();
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL pause k=%0d got=%b exp=%b", k_rel, a, e);
            end
            if (i < 72) begin
                n6  += int'(ce_6m);
                n68 += int'(ce_68k);
                nz  += int'(ce_z80);
            end
        end
        n_checks++;
        if (n6 != 3) begin
            n_fail++;
            $display("FAIL pause_ce6m got=%0d exp=3", n6);
        end
`ifdef NEO_CLK_CE_PAUSE_EN
        n_checks++;
        if (n68 != 0 || nz != 0) begin
            n_fail++;
            $display("FAIL pause_cpu_gate got=%0d/%0d exp=0/0", n68, nz);
        end
`else
        n_checks++;
        if (n68 != 6 || nz != 2) begin
            n_fail++;
            $display("FAIL pause_ignored got=%0d/%0d exp=6/2", n68, nz);
        end
`endif
    endtask

    task automatic test_rst_mid_run();
        logic [W-1:0] e, a;
        for (int i = 0; i < 72 && (k_rel % 72) != 40; i++) begin
            exp_q.push_back(exp_vec(1'b0, k_rel + 1, 1'b0));
            @(negedge clk_sys);
            k_rel++;
            e = exp_q.pop_front();
            a = act_vec();
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL rst_mid_run_pre k=%0d got=%b exp=%b", k_rel, a, e);
            end
        end
        rst = 1'b1;                   // sampled while cnt is 40
        exp_q.push_back(7'b1000000);
        @(negedge clk_sys);
        e = exp_q.pop_front();
        a = act_vec();
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL rst_mid_run got=%b exp=%b", a, e);
        end
        n_checks++;
        if (state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_mid_run_state got=%0d exp=0", state_dbg);
        end
        @(negedge clk_sys);
        rst = 1'b0;                   // pll_locked still 1: next edge is E0
        for (int j = 0; j <= REL + 12; j++) begin
            exp_q.push_back(exp_vec(j < REL, j - REL, 1'b0));
            @(negedge clk_sys);
            e = exp_q.pop_front();
            a = act_vec();
            if (j >= REL - 2 || a !== e) begin
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL rst_relock edge=E%0d got=%b exp=%b", j, a, e);
                end
            end
        end
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        n_checks = 0;
        n_fail = 0;
        k_rel = 0;
        rst = 1'b1;
        pll_locked = 1'b0;
        pause = 1'b0;
        test_reset();
        test_lock_up();
        test_rates();
        test_lock_loss();
        test_lock_glitch();
        test_pause();
        test_rst_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
